// File: rtl/controlador_display.sv
// rtl/controlador_display.sv - multiplexed 4-digit hex 7-segment display scanner
// One shared nibble decoder is time-multiplexed across four digits with optional blanking gaps.

module hex_7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  // Segment order {a,b,c,d,e,f,g}, active-high
  always_comb begin
    case (nibble)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase
  end
endmodule

module controlador_display #(
  parameter int DIV_VARREDURA = 50000,
  parameter int CICLOS_APAGA  = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] valor_in,
  input  logic        carregar_in,
  input  logic [3:0]  mascara_in,
  input  logic        supressao_zeros_in,
  output logic [3:0]  anodo_out,
  output logic [6:0]  seg_out,
  output logic        quadro_fim_out
);
  localparam logic [0:0] EXIBE = 1'b0;
  localparam logic [0:0] APAGA = 1'b1;
  localparam int CW = 21;
  localparam logic [CW-1:0] TC_EXIBE = CW'(DIV_VARREDURA - 1);
  localparam logic [CW-1:0] TC_APAGA = CW'((CICLOS_APAGA == 0) ? 0 : CICLOS_APAGA - 1);

  logic [0:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   valor_ativo_q, valor_ativo_d;
  logic [15:0]   valor_pendente_q, valor_pendente_d;
  logic          pendente_q, pendente_d;
  logic          quadro_q, quadro_d;
  logic          avanca, fronteira;

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    cnt_d            = cnt_q;
    valor_ativo_d    = valor_ativo_q;
    valor_pendente_d = valor_pendente_q;
    pendente_d       = pendente_q;
    avanca           = 1'b0;
    case (state_q)
      EXIBE: begin
        if (cnt_q == TC_EXIBE) begin
          cnt_d = '0;
          if (CICLOS_APAGA == 0) avanca = 1'b1;
          else                   state_d = APAGA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == TC_APAGA) begin
          cnt_d   = '0;
          avanca  = 1'b1;
          state_d = EXIBE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
    if (avanca) idx_d = idx_q + 2'd1;
    fronteira = avanca && (idx_q == 2'd3);
    quadro_d  = fronteira;
    // A strobe on the boundary cycle still lets the older pending value go live first
    if (fronteira && pendente_q) begin
      valor_ativo_d = valor_pendente_q;
      pendente_d    = 1'b0;
    end
    if (carregar_in) begin
      valor_pendente_d = valor_in;
      pendente_d       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= EXIBE;
      idx_q            <= 2'd0;
      cnt_q            <= '0;
      valor_ativo_q    <= 16'h0000;
      valor_pendente_q <= 16'h0000;
      pendente_q       <= 1'b0;
      quadro_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      cnt_q            <= cnt_d;
      valor_ativo_q    <= valor_ativo_d;
      valor_pendente_q <= valor_pendente_d;
      pendente_q       <= pendente_d;
      quadro_q         <= quadro_d;
    end
  end

  logic [3:0] nibble;
  logic [6:0] seg_dec;
  logic       suprimido, visivel;

  always_comb begin
    case (idx_q)
      2'd0: begin nibble = valor_ativo_q[3:0];   suprimido = 1'b0; end
      2'd1: begin nibble = valor_ativo_q[7:4];   suprimido = (valor_ativo_q[15:4] == 12'h000); end
      2'd2: begin nibble = valor_ativo_q[11:8];  suprimido = (valor_ativo_q[15:8] == 8'h00); end
      default: begin nibble = valor_ativo_q[15:12]; suprimido = (valor_ativo_q[15:12] == 4'h0); end
    endcase
  end

  hex_7seg u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  assign visivel        = (state_q == EXIBE) && mascara_in[idx_q] && !(supressao_zeros_in && suprimido);
  assign anodo_out      = visivel ? (4'b0001 << idx_q) : 4'b0000;
  assign seg_out        = visivel ? seg_dec : 7'b0000000;
  assign quadro_fim_out = quadro_q;
endmodule
